// File: rtl/pp_csa_accumulator_if.sv
// pp_csa_accumulator_if
//   Bundles the operand-side and result-side handshakes of the iterative
//   partial-product accumulator.
//   Operand side : in_valid, in_ready, in_a[N-1:0], in_b[N-1:0]
//   Result side  : out_valid, out_ready, out_sum[2N-2:0], out_carry[2N-2:0],
//                  out_hi (weight 2^(2N-1))
//   slave  : the accumulator itself
//   master : whoever supplies operands and consumes the result rows
interface pp_csa_accumulator_if #(
  parameter int N = 14
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_a;
  logic [N-1:0]     in_b;
  logic             out_valid;
  logic             out_ready;
  logic [2*N-2:0]   out_sum;
  logic [2*N-2:0]   out_carry;
  logic             out_hi;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_hi
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_hi
  );
endinterface

// File: rtl/pp_csa_accumulator.sv
// pp_csa_accumulator
//   Iterative partial-product reduction ahead of the final carry-propagate
//   adder. Two unsigned N-bit operands are accepted, then N/2 iterations
//   each fold two partial products into a running carry-save pair (S, C)
//   through one column-wise 4:2 compressor layer. Columns below APPROX_COLS
//   use a cheap approximate compressor; the rest use two chained full adders.
//   Result: out_sum/out_carry (2N-1 bits each) plus out_hi for column 2N-1.
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : pp_csa_accumulator_if.slave (operand and result handshakes)
module pp_csa_accumulator #(
  parameter int N           = 14,
  parameter int APPROX_COLS = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pp_csa_accumulator_if.slave   bus
);

  localparam int W     = 2 * N;
  localparam int ITERS = N / 2;
  localparam int KW    = (ITERS > 1) ? $clog2(ITERS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [W-1:0]   s_q, s_d;
  logic [W-1:0]   c_q, c_d;
  logic [KW-1:0]  k_q, k_d;
  logic [W-2:0]   sum_q, sum_d;
  logic [W-2:0]   carry_q, carry_d;
  logic           hi_q, hi_d;

  logic [W-1:0]   a_ext;
  logic [1:0]     b_pair;
  logic [W-1:0]   pp_lo;
  logic [W-1:0]   pp_hi;
  logic [W-1:0]   s_nx;
  logic [W-1:0]   c_nx;

  // Partial products 2k and 2k+1, already aligned to their column weight.
  always_comb begin
    a_ext  = {{N{1'b0}}, a_q};
    b_pair = 2'(b_q >> {k_q, 1'b0});
    pp_lo  = (a_ext << {k_q, 1'b0}) & {W{b_pair[0]}};
    pp_hi  = (a_ext << {k_q, 1'b1}) & {W{b_pair[1]}};
  end

  // One 4:2 compressor layer across all columns. Approximate columns sit
  // below every exact column and produce no cout, so the horizontal carry
  // chain naturally starts at zero in the lowest exact column.
  always_comb begin
    logic cin;
    logic s1;
    logic cout;
    logic x1, x2, x3, x4;
    logic sm, cy;
    cin  = 1'b0;
    s1   = 1'b0;
    cout = 1'b0;
    sm   = 1'b0;
    cy   = 1'b0;
    s_nx = '0;
    c_nx = '0;
    for (int j = 0; j < W; j++) begin
      x1 = s_q[j];
      x2 = c_q[j];
      x3 = pp_lo[j];
      x4 = pp_hi[j];
      if (j < APPROX_COLS) begin
        cy = (x1 & x2) | (x3 & x4);
        sm = (x1 ^ x2) | (x3 ^ x4);
      end else begin
        s1   = x1 ^ x2 ^ x3;
        cout = (x1 & x2) | (x1 & x3) | (x2 & x3);
        sm   = s1 ^ x4 ^ cin;
        cy   = (s1 & x4) | (s1 & cin) | (x4 & cin);
        cin  = cout;
      end
      s_nx[j] = sm;
      // The carry out of the top column would weigh 2^(2N) and is dropped.
      if (j < W - 1) begin
        c_nx[j+1] = cy;
      end
    end
  end

  // Next-state and datapath register loads.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    c_d     = c_q;
    k_d     = k_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    hi_d    = hi_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          s_d     = '0;
          c_d     = '0;
          k_d     = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        s_d = s_nx;
        c_d = c_nx;
        k_d = k_q + 1'b1;
        if (k_q == KW'(ITERS - 1)) begin
          sum_d   = s_nx[W-2:0];
          carry_d = c_nx[W-2:0];
          hi_d    = s_nx[W-1] | c_nx[W-1];
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      hi_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      c_q     <= c_d;
      k_q     <= k_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      hi_q    <= hi_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_carry = carry_q;
  assign bus.out_hi    = hi_q;

endmodule
